// File: rtl/ones_event_tx.sv
// Serial event-token transmitter. A request carries a count of ones and the
// number of zero cycles between them. The block plays the ones out on `data`,
// flags every GROUP-th one sent since reset on `group_mark`, then pulses
// `done` for one cycle. Every output is a flop, so no input reaches an output
// combinationally.
module ones_event_tx #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [GAP_W-1:0] req_gap,
  output logic             data,
  output logic             group_mark,
  output logic             busy,
  output logic             done
);

  localparam int GRP_W = (GROUP > 2) ? $clog2(GROUP) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;          // ones still to send
  logic [GAP_W-1:0] gap_lat_q, gap_lat_d;  // gap latched at accept
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;  // zero cycles left in this gap
  logic [GRP_W-1:0] grp_q, grp_d;          // ones sent since reset, mod GROUP

  logic data_q, data_d;
  logic group_mark_q, group_mark_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic req_ready_q, req_ready_d;

  // Next-state, counter and output decode for the burst sequencer.
  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    gap_lat_d = gap_lat_q;
    gap_cnt_d = gap_cnt_q;
    grp_d     = grp_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d     = req_count;
          gap_lat_d = req_gap;
          state_d   = (req_count == '0) ? S_DONE : S_ONE;
        end
      end

      S_ONE: begin
        // The one being sent now was flagged from grp_q on entry; advance
        // the group counter as it leaves so the next one sees the new value.
        rem_d = rem_q - CNT_W'(1);
        grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
        if (rem_d == '0) begin
          state_d = S_DONE;
        end else if (gap_lat_q == '0) begin
          state_d = S_ONE;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = gap_lat_q;
        end
      end

      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = S_ONE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies, so they
    // line up with state_q in the cycle they describe.
    data_d       = (state_d == S_ONE);
    group_mark_d = (state_d == S_ONE) && (grp_d == GRP_LAST);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE);
  end

  // State, counters and registered outputs; reset aborts any burst at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      gap_lat_q    <= '0;
      gap_cnt_q    <= '0;
      grp_q        <= '0;
      data_q       <= 1'b0;
      group_mark_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_lat_q    <= gap_lat_d;
      gap_cnt_q    <= gap_cnt_d;
      grp_q        <= grp_d;
      data_q       <= data_d;
      group_mark_q <= group_mark_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign data       = data_q;
  assign group_mark = group_mark_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign req_ready  = req_ready_q;

endmodule
